// File: rtl/hazard_stall_ctrl_if.sv
// D/EX/MEM hazard inputs and pipeline-register controls of hazard_stall_ctrl.
// stall_cnt is present only when HAZARD_STALL_CNT_EN is defined.
interface hazard_stall_ctrl_if;
  logic [4:0] rs_addr_D;
  logic [4:0] rt_addr_D;
  logic [3:0] rs_use_D;
  logic [3:0] rt_use_D;
  logic       md_use_D;
  logic [4:0] dst_addr_E;
  logic [3:0] dst_save_E;
  logic [4:0] dst_addr_M;
  logic [3:0] dst_save_M;
  logic       md_start_E;
  logic       md_op_E;
  logic       en_F;
  logic       en_D;
  logic       flush_E;
  logic       md_busy;
  logic       md_done;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
    output rs_addr_D, rt_addr_D, rs_use_D, rt_use_D, md_use_D,
    output dst_addr_E, dst_save_E, dst_addr_M, dst_save_M, md_start_E, md_op_E,
`ifdef HAZARD_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  en_F, en_D, flush_E, md_busy, md_done
  );

  modport slave (
    input  rs_addr_D, rt_addr_D, rs_use_D, rt_use_D, md_use_D,
    input  dst_addr_E, dst_save_E, dst_addr_M, dst_save_M, md_start_E, md_op_E,
`ifdef HAZARD_STALL_CNT_EN
    output stall_cnt,
`endif
    output en_F, en_D, flush_E, md_busy, md_done
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline plus mult/div busy countdown.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_stall_ctrl_if.slave bus
);
  // A zero duration would never terminate the countdown, so it is clamped to 1.
  localparam logic [3:0] MULT_N = (MULT_CYCLES == 0) ? 4'd1 : 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = (DIV_CYCLES  == 0) ? 4'd1 : 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       stall_rs, stall_rt, stall_md, stall;

  assign stall_rs = (bus.rs_addr_D != 5'd0) &&
                    ((bus.rs_addr_D == bus.dst_addr_E && bus.rs_use_D < bus.dst_save_E) ||
                     (bus.rs_addr_D == bus.dst_addr_M && bus.rs_use_D < bus.dst_save_M));
  assign stall_rt = (bus.rt_addr_D != 5'd0) &&
                    ((bus.rt_addr_D == bus.dst_addr_E && bus.rt_use_D < bus.dst_save_E) ||
                     (bus.rt_addr_D == bus.dst_addr_M && bus.rt_use_D < bus.dst_save_M));
  assign stall_md = bus.md_use_D && (bus.md_busy || bus.md_start_E);
  assign stall    = stall_rs | stall_rt | stall_md;

  // Pipeline keeps flowing while reset is held, whatever the hazard inputs say.
  always_comb begin
    bus.en_F    = 1'b1;
    bus.en_D    = 1'b1;
    bus.flush_E = 1'b0;
    if (reset) begin
      bus.en_F    = ~stall;
      bus.en_D    = ~stall;
      bus.flush_E = stall;
    end
  end

  assign bus.md_busy = (state == BUSY);
  assign bus.md_done = (state == BUSY) && (cnt == 4'd1);

  // A new start always reloads, even in the done cycle, so back-to-back ops have no gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (bus.md_start_E) begin
      state <= BUSY;
      cnt   <= bus.md_op_E ? DIV_N : MULT_N;
    end else if (state == BUSY) begin
      if (cnt <= 4'd1) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus.stall_cnt <= 32'd0;
    else if (stall && bus.stall_cnt != 32'hFFFF_FFFF)
      bus.stall_cnt <= bus.stall_cnt + 32'd1;
  end
`endif
endmodule
